imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_pkg.sv | 24 ++
 rtl/imem_ram.sv | 37 +++
 rtl/imem_responder.sv | 115 +++++++++++
 tb/tb_imem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: filler instruction,
// FSM state encoding and fetch-address field geometry.
package imem_responder_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    // Number of byte-offset bits below the word index in a fetch address.
    localparam int unsigned ADDR_LSB = 2;

    // addi x0,x0,0
    localparam logic [WORD_W-1:0] NOP_WORD_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // Width of the word index for a store of the given depth.
    function automatic int unsigned idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction store: one write port, one synchronous read port, no reset.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write word index
//   wr_data  - word to write
//   rd_addr  - read word index, sampled every edge
//   rd_data  - registered read data
module imem_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Write-first on a same-address collision so the word accepted on the
    // final load edge is visible to the fetch sampled on that same edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a program from a loader, then serves
// single-cycle-latency word fetches to the core, latching a sticky fault on
// misaligned or out-of-range fetch addresses.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   to_imem   - byte fetch address from the core
//   fr_imem   - registered instruction to the core
//   ld_valid  - loader presents ld_data (ld_last marks the final word)
//   ld_ready  - load word accepted this cycle
//   busy      - program not yet runnable
//   fault     - sticky illegal-fetch indication
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned       DEPTH    = 256,
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] to_imem,
    output logic [WORD_W-1:0] fr_imem,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              busy,
    output logic              fault
);

    localparam int unsigned AW = idx_w(DEPTH);
    localparam int unsigned PW = AW + 1;

    state_e            state;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     cnt;
    logic              sel_mem;
    logic [AW-1:0]     rd_idx;
    logic [WORD_W-1:0] rd_data;
    logic              wr_en;
    logic              misaligned;
    logic              out_of_range;

    assign rd_idx       = to_imem[AW+ADDR_LSB-1:ADDR_LSB];
    assign misaligned   = |to_imem[ADDR_LSB-1:0];
    assign out_of_range = |to_imem[ADDR_W-1:AW+ADDR_LSB];
    assign wr_en        = (state == ST_LOAD) && ld_valid;

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (WORD_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wptr[AW-1:0]),
        .wr_data (ld_data),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // Registered select: the RAM holds the read word, sel_mem records whether
    // that word is a loaded location or should be masked to NOP.
    assign fr_imem = sel_mem ? rd_data : NOP_WORD;

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_LOAD;
            wptr     <= '0;
            cnt      <= '0;
            sel_mem  <= 1'b0;
            fault    <= 1'b0;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    sel_mem <= 1'b0;
                    if (ld_valid) begin
                        wptr <= wptr + PW'(1);
                        cnt  <= cnt + PW'(1);
                        // Last word or store full: start running. The first
                        // RUN-cycle output serves the address on this edge.
                        if (ld_last || (wptr == PW'(DEPTH - 1))) begin
                            state    <= ST_RUN;
                            ld_ready <= 1'b0;
                            busy     <= 1'b0;
                            sel_mem  <= !misaligned && !out_of_range &&
                                        ({1'b0, rd_idx} < (cnt + PW'(1)));
                        end
                    end
                end
                ST_RUN: begin
                    if (misaligned || out_of_range) begin
                        state   <= ST_FAULT;
                        fault   <= 1'b1;
                        sel_mem <= 1'b0;
                    end else begin
                        sel_mem <= ({1'b0, rd_idx} < cnt);
                    end
                end
                ST_FAULT: begin
                    sel_mem <= 1'b0;
                end
                default: begin
                    state    <= ST_LOAD;
                    sel_mem  <= 1'b0;
                    ld_ready <= 1'b1;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios with randomized
// data and fetch addresses, checked against a word-array reference model.
module tb_imem_responder;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] to_imem = '0;
    logic [31:0] fr_imem;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        busy;
    logic        fault;

    always #5 clk = ~clk;

    imem_responder #(
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .to_imem  (to_imem),
        .fr_imem  (fr_imem),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .busy     (busy),
        .fault    (fault)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: program image, loaded word count, mode flags.
    logic [31:0] m_mem [DEPTH];
    int          m_cnt   = 0;
    bit          m_run   = 1'b0;
    bit          m_fault = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word the core should see for a legal byte address.
    function automatic logic [31:0] lookup(input logic [31:0] addr);
        int idx;
        idx = int'(addr >> 2);
        return (idx < m_cnt) ? m_mem[idx] : NOP;
    endfunction

    function automatic bit illegal(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        to_imem  = '0;
        tick();
        chk("rst_fr_imem",  fr_imem,         NOP);
        chk("rst_fault",    32'(fault),      32'd0);
        chk("rst_ld_ready", 32'(ld_ready),   32'd1);
        chk("rst_busy",     32'(busy),       32'd1);
        tick();
        rst     = 1'b0;
        m_cnt   = 0;
        m_run   = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        bit loading;
        loading = !m_run && !m_fault;
        chk("ld_ready_pre", 32'(ld_ready), 32'(loading));
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = $urandom;
        if (loading) begin
            m_mem[m_cnt] = data;
            m_cnt++;
            if (last || (m_cnt == DEPTH)) begin
                m_run = 1'b1;
                // The fetch address present on the entering edge is served.
                chk("first_run_fr", fr_imem, lookup(to_imem));
            end
        end
        chk("busy_post", 32'(busy), 32'(!m_run && !m_fault));
    endtask

    task automatic fetch(input logic [31:0] addr);
        to_imem = addr;
        tick();
        if (!m_fault && illegal(addr)) m_fault = 1'b1;
        chk($sformatf("fetch_%h", addr), fr_imem, m_fault ? NOP : lookup(addr));
        chk($sformatf("fault_%h", addr), 32'(fault), 32'(m_fault));
    endtask

    initial begin
        logic [31:0] w;

        // Reset state.
        do_reset();

        // Three-word program, fetch each word, then an unloaded slot.
        load_word(32'h0031_0263, 1'b0);
        load_word(32'h0031_4263, 1'b0);
        load_word(32'h0031_5263, 1'b1);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'hC);
        chk("run_ld_ready", 32'(ld_ready), 32'd0);
        for (int i = 0; i < 12; i++) fetch(32'($urandom_range(0, 7)) << 2);

        // Misaligned fetch faults; fault is sticky and load is ignored.
        fetch(32'h6);
        fetch(32'h0);
        fetch(32'h4);
        load_word($urandom, 1'b1);
        fetch(32'h8);

        // Full-depth load with no ld_last.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_word($urandom, 1'b0);
        end
        load_word(32'hDEAD_BEEF, 1'b1);
        fetch(32'(DEPTH - 1) << 2);
        for (int i = 0; i < 24; i++) fetch(32'($urandom_range(0, DEPTH - 1)) << 2);
        fetch(32'h400);
        fetch(32'h0);

        // Reset mid-load abandons the partial program.
        do_reset();
        load_word($urandom, 1'b0);
        load_word($urandom, 1'b0);
        do_reset();
        w = $urandom;
        load_word(w, 1'b1);
        fetch(32'h4);
        fetch(32'h0);
        chk("new_word0", fr_imem, w);

        // Loader stalls: nothing moves while ld_valid is low.
        do_reset();
        load_word($urandom, 1'b0);
        load_word($urandom, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_busy",  32'(busy),     32'd1);
            chk("stall_ready", 32'(ld_ready), 32'd1);
        end
        load_word($urandom, 1'b1);
        for (int i = 0; i < 4; i++) fetch(32'(i) << 2);

        // Random program lengths with random gaps and random fetches,
        // including occasional out-of-range addresses.
        for (int p = 0; p < 3; p++) begin
            int n;
            do_reset();
            n = int'($urandom_range(1, 20));
            to_imem = 32'($urandom_range(0, 24)) << 2;
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                load_word($urandom, i == n - 1);
            end
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 15) == 0) fetch($urandom | 32'h0000_1000);
                else fetch(32'($urandom_range(0, 31)) << 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
